// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS control tokens and alignment FSM states
package tmds_pkg;

    // Control-period tokens, indexed by {c1,c0}
    localparam logic [9:0] TOKEN_CTL_00 = 10'h354;
    localparam logic [9:0] TOKEN_CTL_01 = 10'h0AB;
    localparam logic [9:0] TOKEN_CTL_10 = 10'h154;
    localparam logic [9:0] TOKEN_CTL_11 = 10'h2AB;

    typedef enum logic [1:0] {
        SEARCH    = 2'd0,
        SLIP_WAIT = 2'd1,
        LOCKED    = 2'd2
    } tmds_state_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// rtl/tmds_symbol_decode.sv - combinational TMDS symbol classifier and 10b-to-8b data decoder
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] i_sym,
    output logic       o_is_ctl,
    output logic [1:0] o_ctl,
    output logic [7:0] o_data
);

    logic [7:0] w_q;
    logic [6:0] w_x;

    always_comb begin
        o_is_ctl = 1'b1;
        o_ctl    = 2'b00;
        case (i_sym)
            TOKEN_CTL_00: o_ctl = 2'b00;
            TOKEN_CTL_01: o_ctl = 2'b01;
            TOKEN_CTL_10: o_ctl = 2'b10;
            TOKEN_CTL_11: o_ctl = 2'b11;
            default:      o_is_ctl = 1'b0;
        endcase
    end

    // bit 9 undoes the DC-balance inversion, bit 8 selects XOR vs XNOR chaining
    assign w_q    = i_sym[9] ? ~i_sym[7:0] : i_sym[7:0];
    assign w_x    = w_q[7:1] ^ w_q[6:0];
    assign o_data = {(i_sym[8] ? w_x : ~w_x), w_q[0]};

endmodule

// File: rtl/tmds_decode.sv
// rtl/tmds_decode.sv - TMDS channel decoder with bitslip-driven symbol alignment
module tmds_decode
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN    = 8,
    parameter int TIMEOUT     = 4096,
    parameter int SLIP_SETTLE = 8
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic [9:0] tmds_in,
    output logic       bitslip,
    output logic       locked,
    output logic       active,
    output logic [1:0] ctl,
    output logic [7:0] pdata,
    output logic [7:0] relock_cnt
);

    localparam int TMO_MAX = (TIMEOUT > SLIP_SETTLE) ? TIMEOUT : SLIP_SETTLE;
    localparam int RUN_W   = $clog2(CTRL_RUN + 1);
    localparam int TMO_W   = $clog2(TMO_MAX + 1);

    localparam logic [RUN_W-1:0] RUN_FULL    = RUN_W'(CTRL_RUN);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] SETTLE_LAST = TMO_W'(SLIP_SETTLE - 1);

    logic [9:0]       r_sym;
    tmds_state_t      r_state;
    logic [RUN_W-1:0] r_run_cnt;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [7:0]       r_relock_cnt;
    logic             r_bitslip;
    logic             r_locked;
    logic             r_active;
    logic [1:0]       r_ctl;
    logic [7:0]       r_pdata;

    logic             w_is_ctl;
    logic [1:0]       w_ctl;
    logic [7:0]       w_data;
    tmds_state_t      w_state_next;
    logic [RUN_W-1:0] w_run_next;
    logic [TMO_W-1:0] w_tmo_next;
    logic             w_run_hit;
    logic             w_slip;
    logic             w_lock_lost;

    tmds_symbol_decode u_symbol_decode (
        .i_sym    (r_sym),
        .o_is_ctl (w_is_ctl),
        .o_ctl    (w_ctl),
        .o_data   (w_data)
    );

    always_comb begin
        w_run_next = '0;
        if (r_state != SLIP_WAIT && w_is_ctl) begin
            w_run_next = (r_run_cnt == RUN_FULL) ? RUN_FULL : r_run_cnt + RUN_W'(1);
        end
    end

    // A full run both qualifies lock and refreshes the timeout once locked
    assign w_run_hit = (r_state != SLIP_WAIT) && w_is_ctl && (w_run_next == RUN_FULL);

    always_comb begin
        w_state_next = r_state;
        w_slip       = 1'b0;
        w_lock_lost  = 1'b0;
        case (r_state)
            SEARCH: begin
                if (w_run_hit) begin
                    w_state_next = LOCKED;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_state_next = SLIP_WAIT;
                    w_slip       = 1'b1;
                end
            end
            SLIP_WAIT: begin
                if (r_tmo_cnt == SETTLE_LAST) begin
                    w_state_next = SEARCH;
                end
            end
            LOCKED: begin
                if (!w_run_hit && r_tmo_cnt == TMO_LAST) begin
                    w_state_next = SEARCH;
                    w_lock_lost  = 1'b1;
                end
            end
            default: w_state_next = SEARCH;
        endcase
    end

    // The same counter times the search/lock timeout and the post-slip settle
    assign w_tmo_next = (w_run_hit || w_state_next != r_state) ? '0 : r_tmo_cnt + TMO_W'(1);

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_sym        <= '0;
            r_state      <= SEARCH;
            r_run_cnt    <= '0;
            r_tmo_cnt    <= '0;
            r_relock_cnt <= '0;
            r_bitslip    <= 1'b0;
            r_locked     <= 1'b0;
            r_active     <= 1'b0;
            r_ctl        <= 2'b00;
            r_pdata      <= '0;
        end else begin
            r_sym     <= tmds_in;
            r_state   <= w_state_next;
            r_run_cnt <= w_run_next;
            r_tmo_cnt <= w_tmo_next;
            r_bitslip <= w_slip;
            r_locked  <= (w_state_next == LOCKED);
            if (w_lock_lost && r_relock_cnt != 8'hFF) begin
                r_relock_cnt <= r_relock_cnt + 8'd1;
            end
            if (w_state_next != LOCKED) begin
                r_active <= 1'b0;
                r_ctl    <= 2'b00;
                r_pdata  <= '0;
            end else if (w_is_ctl) begin
                r_active <= 1'b0;
                r_ctl    <= w_ctl;
                r_pdata  <= '0;
            end else begin
                r_active <= 1'b1;
                r_pdata  <= w_data;
            end
        end
    end

    assign bitslip    = r_bitslip;
    assign locked     = r_locked;
    assign active     = r_active;
    assign ctl        = r_ctl;
    assign pdata      = r_pdata;
    assign relock_cnt = r_relock_cnt;

endmodule

// File: tb/tb_tmds_decode.sv
// tb/tb_tmds_decode.sv - directed self-checking bench for tmds_decode
module tb_tmds_decode;

    localparam int CTRL_RUN    = 8;
    localparam int TIMEOUT     = 4096;
    localparam int SLIP_SETTLE = 8;

    logic       pixel_clk = 1'b0;
    logic       rst       = 1'b1;
    logic [9:0] tmds_in   = '0;
    logic       bitslip;
    logic       locked;
    logic       active;
    logic [1:0] ctl;
    logic [7:0] pdata;
    logic [7:0] relock_cnt;

    int n_cmp = 0;
    int n_err = 0;

    tmds_decode #(
        .CTRL_RUN    (CTRL_RUN),
        .TIMEOUT     (TIMEOUT),
        .SLIP_SETTLE (SLIP_SETTLE)
    ) dut (
        .pixel_clk  (pixel_clk),
        .rst        (rst),
        .tmds_in    (tmds_in),
        .bitslip    (bitslip),
        .locked     (locked),
        .active     (active),
        .ctl        (ctl),
        .pdata      (pdata),
        .relock_cnt (relock_cnt)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        logic [9:0] sym;
        logic       act;
        logic [1:0] ctl;
        logic [7:0] pd;
    } vec_t;

    vec_t vecs [11];

    logic [9:0] dsym  [4];
    logic [7:0] dbyte [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one symbol and advance one clock; outputs then reflect the symbol of the previous step
    task automatic step(input logic [9:0] sym);
        tmds_in = sym;
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst     = 1'b1;
        tmds_in = '0;
        @(posedge pixel_clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [9:0] rotr(input logic [9:0] v, input int k);
        logic [19:0] w;
        w = {v, v} >> k;
        return w[9:0];
    endfunction

    function automatic logic [9:0] token(input logic [1:0] c);
        case (c)
            2'b00:   return 10'h354;
            2'b01:   return 10'h0AB;
            2'b10:   return 10'h154;
            default: return 10'h2AB;
        endcase
    endfunction

    bit         seen;
    int         n;
    int         off;
    int         pulses;
    int         last_t;
    int         min_gap;
    int         err_lock;
    int         err_ctl;
    int         err_data;
    logic       p_act;
    logic [1:0] p_ctl;
    logic [7:0] p_pd;
    logic [1:0] held;
    logic       vs;
    logic       hs;
    logic       is_data;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // data symbols: 0x100->00, 0x200->FF (inverted/XNOR), 0x09C->5A, 0x263->5A, 0x155->FF, 0x355->FE
        vecs[0]  = '{10'h100, 1'b1, 2'b00, 8'h00};
        vecs[1]  = '{10'h200, 1'b1, 2'b00, 8'hFF};
        vecs[2]  = '{10'h09C, 1'b1, 2'b00, 8'h5A};
        vecs[3]  = '{10'h0AB, 1'b0, 2'b01, 8'h00};
        vecs[4]  = '{10'h263, 1'b1, 2'b01, 8'h5A};
        vecs[5]  = '{10'h2AB, 1'b0, 2'b11, 8'h00};
        vecs[6]  = '{10'h155, 1'b1, 2'b11, 8'hFF};
        vecs[7]  = '{10'h154, 1'b0, 2'b10, 8'h00};
        vecs[8]  = '{10'h354, 1'b0, 2'b00, 8'h00};
        vecs[9]  = '{10'h355, 1'b1, 2'b00, 8'hFE};
        vecs[10] = '{10'h154, 1'b0, 2'b10, 8'h00};

        dsym[0] = 10'h100; dbyte[0] = 8'h00;
        dsym[1] = 10'h200; dbyte[1] = 8'hFF;
        dsym[2] = 10'h09C; dbyte[2] = 8'h5A;
        dsym[3] = 10'h155; dbyte[3] = 8'hFF;

        // Reset state
        pulse_reset();
        chk("reset_outputs", {bitslip, locked, active, ctl, pdata, relock_cnt}, 0);

        // 8 tokens then the vector table, each output checked two clocks after its input
        for (int i = 0; i < 8; i++) step(10'h354);
        chk("no_lock_after_7_tokens", locked, 0);
        for (int i = 0; i <= 11; i++) begin
            step(i < 11 ? vecs[i].sym : 10'h354);
            if (i == 0) begin
                chk("lock_on_8th_token", {locked, active, ctl, pdata}, {1'b1, 1'b0, 2'b00, 8'h00});
            end else begin
                chk($sformatf("vec%0d", i - 1), {locked, active, ctl, pdata},
                    {1'b1, vecs[i-1].act, vecs[i-1].ctl, vecs[i-1].pd});
            end
        end

        // 7 tokens, one data symbol, 7 tokens: no lock; the 8th consecutive token locks
        pulse_reset();
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(i == 7 ? 10'h100 : 10'h354);
            if (locked) seen = 1'b1;
        end
        chk("broken_run_no_lock", seen, 0);
        step(10'h354);
        chk("run_of_8_locks", locked, 1);

        // Data only: lock drops after TIMEOUT data symbols, counted, without a slip
        n    = 0;
        seen = 1'b0;
        while (locked && n < 5000) begin
            step(10'h100);
            n++;
            if (bitslip) seen = 1'b1;
        end
        chk("data_symbols_until_loss", n - 1, TIMEOUT);
        chk("loss_outputs", {locked, active, ctl, pdata, bitslip}, 0);
        chk("relock_cnt_after_loss", relock_cnt, 1);
        chk("no_slip_during_lock_loss", seen, 0);

        // Relock, then a one-cycle reset while locked clears everything including relock_cnt
        for (int i = 0; i < 9; i++) step(10'h354);
        chk("relocked_before_reset", {locked, relock_cnt}, {1'b1, 8'd1});
        pulse_reset();
        chk("midrun_reset_outputs", {bitslip, locked, active, ctl, pdata, relock_cnt}, 0);
        for (int i = 0; i < 8; i++) step(10'h354);
        chk("post_reset_no_lock_7", locked, 0);
        step(10'h100);
        chk("post_reset_lock", {locked, active}, {1'b1, 1'b0});
        step(10'h200);
        chk("post_reset_px00", {locked, active, pdata}, {1'b1, 1'b1, 8'h00});
        step(10'h09C);
        chk("post_reset_pxFF", {locked, active, pdata}, {1'b1, 1'b1, 8'hFF});
        step(10'h354);
        chk("post_reset_px5A", {locked, active, pdata}, {1'b1, 1'b1, 8'h5A});

        // 1650-cycle lines with 370 blanking tokens; 3 short frames of 6 lines, vsync on line 0
        err_lock = 0;
        err_ctl  = 0;
        err_data = 0;
        held     = 2'b00;
        p_act    = 1'b0;
        p_ctl    = 2'b00;
        p_pd     = 8'h00;
        for (int ln = 0; ln < 18; ln++) begin
            for (int x = 0; x < 1650; x++) begin
                vs      = ((ln % 6) == 0);
                hs      = (x >= 1280 + 110) && (x < 1280 + 150);
                is_data = ((ln % 6) >= 2) && (x < 1280);
                step(is_data ? dsym[x % 4] : token({vs, hs}));
                if (locked !== 1'b1) err_lock++;
                if (ctl !== p_ctl) err_ctl++;
                if (active !== p_act || pdata !== p_pd) err_data++;
                if (is_data) begin
                    p_act = 1'b1;
                    p_ctl = held;
                    p_pd  = dbyte[x % 4];
                end else begin
                    held  = {vs, hs};
                    p_act = 1'b0;
                    p_ctl = held;
                    p_pd  = 8'h00;
                end
            end
        end
        chk("video_lock_errors", err_lock, 0);
        chk("video_ctl_errors", err_ctl, 0);
        chk("video_data_errors", err_data, 0);
        chk("video_relock_cnt", relock_cnt, 0);

        // Token stream rotated by 3 bits; each bitslip pulse removes one bit of rotation
        pulse_reset();
        off     = 3;
        pulses  = 0;
        last_t  = 0;
        min_gap = 1_000_000;
        n       = 0;
        while (!locked && n < 20000) begin
            step(rotr(10'h354, off));
            n++;
            if (bitslip) begin
                pulses++;
                if (pulses > 1 && (n - last_t) < min_gap) min_gap = n - last_t;
                last_t = n;
                off    = (off + 9) % 10;
            end
        end
        chk("slip_then_lock", locked, 1);
        chk("slip_pulse_count", pulses, 3);
        chk("slip_gap_ok", (min_gap >= SLIP_SETTLE + 1), 1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(10'h354);
            if (bitslip || !locked) seen = 1'b1;
        end
        chk("stable_after_align", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
